des_key_schedule: RTL and testbench
===================================

// Module: des_key_schedule
// PURPOSE
//   Sequential DES key schedule: accepts one 64-bit key, applies PC-1, then streams the 16 round subkeys.
//   Each subkey is C/D rotation followed by PC-2, 48 bits, one per valid/ready handshake.
//   Supports encrypt order (K1..K16) and decrypt order (K16..K1) without precomputing a table.
//   Sits between the key register and the DES round datapath; reusable per stage for 3DES.
// PARAMETERS
//   CHECK_PARITY  1  1: reject keys whose bytes are not odd parity; 0: ignore parity bits
//   ZERO_IDLE     1  1: subkey_out forced to 0 whenever subkey_valid=0; 0: holds last value
// PORTS
//   clk           in   1   single clock, all state on rising edge
//   rst           in   1   synchronous, active-high reset
//   start         in   1   key load request, sampled only in IDLE
//   decrypt       in   1   sampled with start; 0 = K1..K16, 1 = K16..K1
//   key_in        in   [1:64]  DES key, FIPS 46-3 bit numbering (bit 1 = MSB)
//   subkey_out    out  [47:0]  current subkey; bit 47 = FIPS PC-2 output bit 1
//   subkey_valid  out  1   subkey_out/round_idx valid
//   subkey_ready  in   1   consumer accepts subkey this cycle
//   round_idx     out  4   round number of subkey_out minus 1 (K1 -> 0, K16 -> 15)
//   busy          out  1   high from accepted start until final handshake
//   done          out  1   one-cycle pulse, cycle after the 16th handshake
//   parity_err    out  1   one-cycle pulse, cycle after a start rejected for parity
// BEHAVIOUR
//   Reset: state=IDLE; C,D,round counter=0; subkey_valid, busy, done, parity_err=0; subkey_out=0.
//   FSM: IDLE -> RUN on start (parity OK); RUN -> DONE on 16th handshake; DONE -> IDLE (1 cycle, done=1).
//   start in IDLE with parity fail (CHECK_PARITY=1): stay IDLE, parity_err=1 next cycle, C/D untouched.
//   start while busy or in DONE: ignored, no side effects. rst and start together: rst wins.
//   Handshake = subkey_valid & subkey_ready. Latency: start at edge t -> subkey_valid=1 after edge t+1.
//   Shift schedule s[r], r=1..16: 1 for r in {1,2,9,16}, else 2. Total rotation = 28.
//   Encrypt load: C,D = rotl28(PC1(key), 1) -> K1. On handshake of round r<16: rotl by s[r+1].
//   Decrypt load: C,D = PC1(key), which equals C16/D16 -> K16. On handshake of round r>1: rotr by s[r].
//   subkey_out = PC2({C,D}) combinationally from C/D registers; with ZERO_IDLE=1 it is gated by subkey_valid.
//   round_idx increments (encrypt) or decrements (decrypt) per handshake. It is 0 outside RUN.
//   Stall (valid & !ready): subkey_out, round_idx, C, D held stable, any number of cycles.
//   After the last handshake, subkey_valid drops the same edge; busy drops with done pulse.
//   rst mid-RUN: all state returns to reset values next edge; partial stream abandoned, no done.
//   Parity check: each key_in byte must contain an odd number of ones. Bits 8,16..64 are not otherwise used.
// STRUCTURE
//   des_pkg: PC1 table (56 entries), PC2 table (48), shift schedule s[1..16], localparam ROUNDS=16,
//     FSM state encoding (IDLE/RUN/DONE), rotl28/rotr28 functions.
//   One sub-module des_pc2_perm: pure combinational {C,D}[1:56] -> [47:0].
//   PC-1 is inline; the rest is FSM + 28-bit C/D registers + 4-bit counter.
// TESTING
//   Key 0x133457799BBCDFF1, decrypt=0: first subkey 0x1B02EFFC7072 (idx 0), 16th 0xCB3D8B0E17F5 (idx 15), done pulse.
//   Same key, decrypt=1: first subkey 0xCB3D8B0E17F5 (idx 15), last 0x1B02EFFC7072 (idx 0).
//     Full sequence is the exact reverse of encrypt.
//   Random ready toggling (incl. 5-cycle stall on idx 7): outputs stable during stall, 16 handshakes, no skip/repeat.
//   Key 0x133457799BBCDFF0, CHECK_PARITY=1: parity_err pulse, busy stays 0, no valid.
//     With CHECK_PARITY=0: stream starts.
//   start pulsed mid-RUN: ignored, sequence unchanged. rst at idx 9: valid/busy=0 next cycle, no done.
//     Fresh start then works.
//   ZERO_IDLE=1: subkey_out==0 whenever valid=0. Scoreboard vs reference model over 1000 random keys, both modes.

Source files
------------

// File: rtl/des_key_schedule_pkg.sv
// Shared tables, state encoding and C/D rotate helpers for the DES key schedule.
package des_key_schedule_pkg;

    localparam int unsigned ROUNDS = 16;

    // Entries are FIPS bit numbers (1 = MSB) of the 64-bit key.
    localparam int unsigned PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // Entries are bit numbers (1 = MSB) of the 56-bit {C,D}.
    localparam int unsigned PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // SHIFTS[r-1] is the left rotation applied to reach round r.
    localparam int unsigned SHIFTS [ROUNDS] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    function automatic logic [27:0] rotl28(input logic [27:0] v, input logic [1:0] n);
        return (n == 2'd2) ? {v[25:0], v[27:26]} : (n == 2'd1) ? {v[26:0], v[27]} : v;
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] v, input logic [1:0] n);
        return (n == 2'd2) ? {v[1:0], v[27:2]} : (n == 2'd1) ? {v[0], v[27:1]} : v;
    endfunction

endpackage

// File: rtl/des_key_schedule_pc2_perm.sv
// PC-2 compression: 56-bit {C,D} (bit 55 = FIPS bit 1) to a 48-bit subkey.
module des_key_schedule_pc2_perm
    import des_key_schedule_pkg::*;
(
    input  logic [55:0] i_cd,
    output logic [47:0] o_subkey
);

    always_comb begin
        o_subkey = '0;
        for (int j = 0; j < 48; j++) begin
            o_subkey[6'(47 - j)] = i_cd[6'(56 - PC2[j])];
        end
    end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: loads one key through PC-1 and streams 16 subkeys over
// valid/ready, in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_schedule
    import des_key_schedule_pkg::*;
#(
    parameter bit CHECK_PARITY = 1'b1,
    parameter bit ZERO_IDLE    = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_decrypt,
    input  logic [63:0] i_key_in,
    output logic [47:0] o_subkey_out,
    output logic        o_subkey_valid,
    input  logic        i_subkey_ready,
    output logic [3:0]  o_round_idx,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_parity_err
);

    state_e      r_state, w_state_next;
    logic [27:0] r_c, r_d, w_c_next, w_d_next;
    logic [3:0]  r_idx, w_idx_next;
    logic        r_dec, w_dec_next;
    logic        r_parity_err, w_parity_err_next;
    logic [55:0] w_pc1;
    logic [47:0] w_pc2;
    logic        w_parity_ok, w_hs, w_last;

    always_comb begin
        w_pc1 = '0;
        for (int i = 0; i < 56; i++) begin
            w_pc1[6'(55 - i)] = i_key_in[6'(64 - PC1[i])];
        end
    end

    always_comb begin
        w_parity_ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (!(^i_key_in[8*b +: 8])) w_parity_ok = 1'b0;
        end
    end

    assign w_hs   = (r_state == StRun) && i_subkey_ready;
    assign w_last = r_dec ? (r_idx == 4'd0) : (r_idx == 4'(ROUNDS - 1));

    always_comb begin
        w_state_next      = r_state;
        w_c_next          = r_c;
        w_d_next          = r_d;
        w_idx_next        = r_idx;
        w_dec_next        = r_dec;
        w_parity_err_next = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    if (CHECK_PARITY && !w_parity_ok) begin
                        w_parity_err_next = 1'b1;
                    end else begin
                        w_state_next = StRun;
                        w_dec_next   = i_decrypt;
                        // PC-1 output is already C16/D16 since the total rotation is 28.
                        if (i_decrypt) begin
                            w_c_next   = w_pc1[55:28];
                            w_d_next   = w_pc1[27:0];
                            w_idx_next = 4'(ROUNDS - 1);
                        end else begin
                            w_c_next   = rotl28(w_pc1[55:28], 2'd1);
                            w_d_next   = rotl28(w_pc1[27:0], 2'd1);
                            w_idx_next = 4'd0;
                        end
                    end
                end
            end
            StRun: begin
                if (w_hs) begin
                    if (w_last) begin
                        w_state_next = StDone;
                        w_idx_next   = 4'd0;
                    end else if (r_dec) begin
                        w_c_next   = rotr28(r_c, 2'(SHIFTS[r_idx]));
                        w_d_next   = rotr28(r_d, 2'(SHIFTS[r_idx]));
                        w_idx_next = r_idx - 4'd1;
                    end else begin
                        w_c_next   = rotl28(r_c, 2'(SHIFTS[r_idx + 4'd1]));
                        w_d_next   = rotl28(r_d, 2'(SHIFTS[r_idx + 4'd1]));
                        w_idx_next = r_idx + 4'd1;
                    end
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_c          <= '0;
            r_d          <= '0;
            r_idx        <= '0;
            r_dec        <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_c          <= w_c_next;
            r_d          <= w_d_next;
            r_idx        <= w_idx_next;
            r_dec        <= w_dec_next;
            r_parity_err <= w_parity_err_next;
        end
    end

    des_key_schedule_pc2_perm u_pc2 (
        .i_cd     ({r_c, r_d}),
        .o_subkey (w_pc2)
    );

    assign o_subkey_valid = (r_state == StRun);
    assign o_busy         = (r_state == StRun);
    assign o_done         = (r_state == StDone);
    assign o_parity_err   = r_parity_err;
    assign o_round_idx    = r_idx;
    assign o_subkey_out   = (ZERO_IDLE && !o_subkey_valid) ? 48'd0 : w_pc2;

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: reference key schedule, directed FIPS vectors,
// stalls, parity rejection, mid-run start/reset and random keys.
module tb_des_key_schedule;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] KEY_OK  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;
    localparam logic [47:0] K1      = 48'h1B02EFFC7072;
    localparam logic [47:0] K16     = 48'hCB3D8B0E17F5;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, decrypt = 1'b0, ready = 1'b0;
    logic        start2 = 1'b0, ready2 = 1'b0;
    logic [63:0] key = '0;
    logic [47:0] sub, sub2;
    logic [3:0]  idx, idx2;
    logic        valid, busy, done, perr, valid2, busy2, done2, perr2;

    int          n_checks = 0, n_errors = 0, done_cnt = 0;
    logic [51:0] sb_q [$];
    logic [51:0] mon_exp;
    logic [47:0] last_sub = '0, p_sub = '0;
    logic [3:0]  p_idx = '0;
    logic        p_stall = 1'b0;
    logic [47:0] ref_ks [16];

    always #5 clk = ~clk;

    des_key_schedule u_dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_decrypt      (decrypt),
        .i_key_in       (key),
        .o_subkey_out   (sub),
        .o_subkey_valid (valid),
        .i_subkey_ready (ready),
        .o_round_idx    (idx),
        .o_busy         (busy),
        .o_done         (done),
        .o_parity_err   (perr)
    );

    des_key_schedule #(
        .CHECK_PARITY (1'b0),
        .ZERO_IDLE    (1'b0)
    ) u_dut_np (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start2),
        .i_decrypt      (decrypt),
        .i_key_in       (key),
        .o_subkey_out   (sub2),
        .o_subkey_valid (valid2),
        .i_subkey_ready (ready2),
        .o_round_idx    (idx2),
        .o_busy         (busy2),
        .o_done         (done2),
        .o_parity_err   (perr2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Textbook schedule: cumulative single-bit left rotations from C0/D0, then PC-2.
    task automatic ref_schedule(input logic [63:0] k);
        logic [55:0] cd;
        logic [27:0] c, d;
        cd = '0;
        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = k[6'(64 - PC1_T[i])];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SH_T[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) ref_ks[r][6'(47 - j)] = cd[6'(56 - PC2_T[j])];
        end
    endtask

    function automatic logic [63:0] fix_parity(input logic [63:0] v);
        logic [63:0] r;
        r = v;
        for (int b = 0; b < 8; b++) r[8*b] = ~^r[8*b+1 +: 7];
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready) begin
                check_eq("sb_nonempty", 64'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    mon_exp = sb_q.pop_front();
                    check_eq("subkey", {idx, sub}, mon_exp);
                    last_sub = sub;
                end
            end
            if (!valid) check_eq("zero_idle", sub, 0);
            if (p_stall) check_eq("stall_hold", {valid, idx, sub}, {1'b1, p_idx, p_sub});
        end
        if (done) done_cnt++;
        p_stall = valid && !ready && !rst;
        p_idx   = idx;
        p_sub   = sub;
    end

    // mode 0: ready high; 1: random ready; 2: random plus 5 forced stall cycles on idx 7.
    task automatic run_stream(input logic [63:0] k, input logic dec, input int mode,
                              input bit poke, input bit chk,
                              input logic [47:0] first_exp, input logic [47:0] last_exp);
        int budget, stall, done0;
        ref_schedule(k);
        for (int r = 0; r < 16; r++) begin
            int j;
            j = dec ? 15 - r : r;
            sb_q.push_back({4'(j), ref_ks[j]});
        end
        done0   = done_cnt;
        key     = k;
        decrypt = dec;
        ready   = 1'b0;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("lat_valid", valid, 1);
        check_eq("lat_busy", busy, 1);
        check_eq("lat_idx", idx, dec ? 15 : 0);
        if (chk) check_eq("k_first", sub, first_exp);
        budget = 0;
        stall  = 0;
        while (!done && budget < 400) begin
            start   = 1'b0;
            key     = k;
            decrypt = dec;
            if (poke && budget == 5) begin
                start   = 1'b1;
                key     = ~k;
                decrypt = ~dec;
            end
            case (mode)
                0: ready = 1'b1;
                1: ready = 1'($urandom_range(0, 1));
                default: begin
                    if (valid && idx == 4'd7 && stall < 5) begin
                        ready = 1'b0;
                        stall++;
                    end else begin
                        ready = 1'($urandom_range(0, 1));
                    end
                end
            endcase
            @(posedge clk); #1;
            budget++;
        end
        start = 1'b0;
        ready = 1'b0;
        check_eq("done_seen", done, 1);
        check_eq("done_busy", busy, 0);
        check_eq("done_valid", valid, 0);
        check_eq("done_idx", idx, 0);
        check_eq("sb_left", sb_q.size(), 0);
        if (mode == 2) check_eq("stall_len", stall, 5);
        if (chk) check_eq("k_last", last_sub, last_exp);
        @(posedge clk); #1;
        check_eq("done_pulse", done, 0);
        check_eq("done_count", done_cnt - done0, 1);
        sb_q.delete();
    endtask

    initial begin
        int budget, hs, done0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_perr", perr, 0);
        check_eq("rst_idx", idx, 0);
        check_eq("rst_sub", sub, 0);
        check_eq("rst_sub_np", sub2, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_valid", valid, 0);

        run_stream(KEY_OK, 1'b0, 0, 1'b0, 1'b1, K1, K16);
        run_stream(KEY_OK, 1'b1, 0, 1'b0, 1'b1, K16, K1);
        run_stream(KEY_OK, 1'b0, 2, 1'b0, 1'b1, K1, K16);
        run_stream(KEY_OK, 1'b1, 2, 1'b0, 1'b1, K16, K1);
        run_stream(KEY_OK, 1'b0, 1, 1'b1, 1'b1, K1, K16);

        // Bad parity: rejected by the checking instance, accepted by the other.
        key     = KEY_BAD;
        decrypt = 1'b0;
        start   = 1'b1;
        start2  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        start2 = 1'b0;
        check_eq("perr_pulse", perr, 1);
        check_eq("perr_busy", busy, 0);
        check_eq("perr_valid", valid, 0);
        check_eq("np_perr", perr2, 0);
        check_eq("np_busy", busy2, 1);
        check_eq("np_first", sub2, K1);
        check_eq("np_idx", idx2, 0);
        @(posedge clk); #1;
        check_eq("perr_clear", perr, 0);
        check_eq("perr_valid2", valid, 0);
        ready2 = 1'b1;
        budget = 0;
        hs     = 0;
        while (!done2 && budget < 100) begin
            if (valid2) hs++;
            @(posedge clk); #1;
            budget++;
        end
        ready2 = 1'b0;
        check_eq("np_done", done2, 1);
        check_eq("np_hs", hs, 16);
        check_eq("np_hold", sub2, K16);
        @(posedge clk); #1;

        // Reset in the middle of a stream.
        ref_schedule(KEY_OK);
        for (int r = 0; r < 16; r++) sb_q.push_back({4'(r), ref_ks[r]});
        done0 = done_cnt;
        key   = KEY_OK;
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        ready  = 1'b1;
        budget = 0;
        while (idx != 4'd9 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        check_eq("rst_reach9", idx, 9);
        rst = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        ready = 1'b0;
        sb_q.delete();
        check_eq("mrst_valid", valid, 0);
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_idx", idx, 0);
        repeat (4) @(posedge clk);
        #1;
        check_eq("mrst_nodone", done_cnt - done0, 0);
        run_stream(KEY_OK, 1'b1, 0, 1'b0, 1'b1, K16, K1);

        for (int n = 0; n < 1000; n++) begin
            logic [63:0] k;
            k = fix_parity({$urandom, $urandom});
            run_stream(k, 1'(n & 1), (n % 10 == 0) ? 1 : 0, 1'b0, 1'b0, '0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
